// File: rtl/multi_word_decoder_if.sv
// Fetch/decode bus of the multi-word instruction decoder.
// The master side drives the fetch stream and the consumer handshake; the decoder is the slave.
interface multi_word_decoder_if #(
  parameter int DATA_W   = 16,
  parameter int MAX_ARGS = 2
);
  logic                       i_fetch_valid;
  logic [DATA_W-1:0]          i_fetch_data;
  logic                       o_fetch_ready;
  logic                       i_interrupt;
  logic                       i_int_return;
  logic                       o_dec_valid;
  logic                       i_dec_ready;
  logic [DATA_W-3:0]          o_dec_opcode;
  logic [MAX_ARGS*DATA_W-1:0] o_dec_args;
  logic [1:0]                 o_dec_nargs;
  logic                       o_illegal;
  logic                       o_int_overflow;

  modport master (
    output i_fetch_valid, i_fetch_data, i_interrupt, i_int_return, i_dec_ready,
    input  o_fetch_ready, o_dec_valid, o_dec_opcode, o_dec_args, o_dec_nargs,
           o_illegal, o_int_overflow
  );

  modport slave (
    input  i_fetch_valid, i_fetch_data, i_interrupt, i_int_return, i_dec_ready,
    output o_fetch_ready, o_dec_valid, o_dec_opcode, o_dec_args, o_dec_nargs,
           o_illegal, o_int_overflow
  );
endinterface

// File: rtl/multi_word_decoder.sv
// Collects an opcode word plus up to MAX_ARGS argument words into one decoded instruction,
// with a one-deep shadow that parks a partial instruction across an interrupt.
module multi_word_decoder #(
  parameter int DATA_W   = 16,
  parameter int MAX_ARGS = 2
) (
  input logic                  clk,
  input logic                  rst,
  multi_word_decoder_if.slave  bus
);
  localparam int OPC_W  = DATA_W - 2;
  localparam int ARGS_W = MAX_ARGS * DATA_W;

  typedef enum logic [1:0] {OPC, ARG, ISSUE} state_e;

  state_e            state_q, state_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d, sh_opcode_q, sh_opcode_d;
  logic [1:0]        nargs_q, nargs_d, sh_nargs_q, sh_nargs_d;
  logic [1:0]        cnt_q, cnt_d, sh_cnt_q, sh_cnt_d;
  logic [ARGS_W-1:0] args_q, args_d, sh_args_q, sh_args_d;
  logic              sh_valid_q, sh_valid_d;
  logic              illegal_q, illegal_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic [1:0]        word_n;
  logic [OPC_W-1:0]  word_opc;

  assign word_n   = bus.i_fetch_data[DATA_W-1 -: 2];
  assign word_opc = bus.i_fetch_data[OPC_W-1:0];
  assign accept   = bus.i_fetch_valid && (state_q != ISSUE);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    opcode_d    = opcode_q;
    nargs_d     = nargs_q;
    cnt_d       = cnt_q;
    args_d      = args_q;
    sh_opcode_d = sh_opcode_q;
    sh_nargs_d  = sh_nargs_q;
    sh_cnt_d    = sh_cnt_q;
    sh_args_d   = sh_args_q;
    sh_valid_d  = sh_valid_q;
    illegal_d   = 1'b0;
    ovf_d       = 1'b0;

    case (state_q)
      OPC: begin
        // An interrupt in the same cycle suppresses a return; the fetched word is dropped.
        if (bus.i_int_return && !bus.i_interrupt && sh_valid_q) begin
          opcode_d   = sh_opcode_q;
          nargs_d    = sh_nargs_q;
          cnt_d      = sh_cnt_q;
          args_d     = sh_args_q;
          sh_valid_d = 1'b0;
          state_d    = ARG;
        end else if (accept) begin
          if (int'(word_n) > MAX_ARGS) begin
            illegal_d = 1'b1;
          end else if (!(word_n == 2'd0 && word_opc == '0)) begin
            opcode_d = word_opc;
            nargs_d  = word_n;
            cnt_d    = 2'd0;
            args_d   = '0;
            state_d  = (word_n == 2'd0) ? ISSUE : ARG;
          end
        end
      end
      ARG: begin
        if (bus.i_interrupt) begin
          sh_opcode_d = opcode_q;
          sh_nargs_d  = nargs_q;
          sh_cnt_d    = cnt_q;
          sh_args_d   = args_q;
          ovf_d       = sh_valid_q;
          sh_valid_d  = 1'b1;
          opcode_d    = '0;
          nargs_d     = 2'd0;
          cnt_d       = 2'd0;
          args_d      = '0;
          state_d     = OPC;
        end else if (accept) begin
          for (int k = 0; k < MAX_ARGS; k++) begin
            if (cnt_q == 2'(k)) args_d[k*DATA_W +: DATA_W] = bus.i_fetch_data;
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_d == nargs_q) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_dec_ready) state_d = OPC;
      end
      default: state_d = OPC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OPC;
      opcode_q    <= '0;
      nargs_q     <= 2'd0;
      cnt_q       <= 2'd0;
      args_q      <= '0;
      sh_opcode_q <= '0;
      sh_nargs_q  <= 2'd0;
      sh_cnt_q    <= 2'd0;
      sh_args_q   <= '0;
      sh_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      nargs_q     <= nargs_d;
      cnt_q       <= cnt_d;
      args_q      <= args_d;
      sh_opcode_q <= sh_opcode_d;
      sh_nargs_q  <= sh_nargs_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_args_q   <= sh_args_d;
      sh_valid_q  <= sh_valid_d;
      illegal_q   <= illegal_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.o_fetch_ready  = (state_q != ISSUE);
  assign bus.o_dec_valid    = (state_q == ISSUE);
  assign bus.o_dec_opcode   = opcode_q;
  assign bus.o_dec_args     = args_q;
  assign bus.o_dec_nargs    = nargs_q;
  assign bus.o_illegal      = illegal_q;
  assign bus.o_int_overflow = ovf_q;
endmodule

// File: tb/tb_multi_word_decoder.sv
// Directed bench for multi_word_decoder: a scoreboard queue holds expected instructions,
// popped and compared whenever the decoder completes an issue handshake.
module tb_multi_word_decoder;
  localparam int DATA_W   = 16;
  localparam int MAX_ARGS = 2;

  typedef struct packed {
    logic [DATA_W-3:0]          opc;
    logic [MAX_ARGS*DATA_W-1:0] args;
    logic [1:0]                 nargs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multi_word_decoder_if #(.DATA_W(DATA_W), .MAX_ARGS(MAX_ARGS)) tb_if ();

  multi_word_decoder #(.DATA_W(DATA_W), .MAX_ARGS(MAX_ARGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tb_if.slave)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ill_cnt  = 0;
  int   ovf_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard monitor and pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (tb_if.o_illegal)      ill_cnt++;
      if (tb_if.o_int_overflow) ovf_cnt++;
      if (tb_if.o_dec_valid && tb_if.i_dec_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_issue", 64'(tb_if.o_dec_opcode), 64'h3fff_ffff);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_opcode", 64'(tb_if.o_dec_opcode), 64'(e.opc));
          check("sb_args",   64'(tb_if.o_dec_args),   64'(e.args));
          check("sb_nargs",  64'(tb_if.o_dec_nargs),  64'(e.nargs));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [DATA_W-1:0] w);
    bit ok = 1'b0;
    tb_if.i_fetch_valid = 1'b1;
    tb_if.i_fetch_data  = w;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (tb_if.o_fetch_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("fetch_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    tb_if.i_fetch_valid = 1'b0;
  endtask

  task automatic pulse_int();
    tb_if.i_interrupt = 1'b1;
    @(posedge clk);
    #1;
    tb_if.i_interrupt = 1'b0;
  endtask

  task automatic pulse_ret();
    tb_if.i_int_return = 1'b1;
    @(posedge clk);
    #1;
    tb_if.i_int_return = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dec_valid"},   64'(tb_if.o_dec_valid),    64'(0));
    check({tag, "_opcode"},      64'(tb_if.o_dec_opcode),   64'(0));
    check({tag, "_args"},        64'(tb_if.o_dec_args),     64'(0));
    check({tag, "_nargs"},       64'(tb_if.o_dec_nargs),    64'(0));
    check({tag, "_illegal"},     64'(tb_if.o_illegal),      64'(0));
    check({tag, "_overflow"},    64'(tb_if.o_int_overflow), 64'(0));
    check({tag, "_fetch_ready"}, 64'(tb_if.o_fetch_ready),  64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ill0, ovf0;
    tb_if.i_fetch_valid = 1'b0;
    tb_if.i_fetch_data  = '0;
    tb_if.i_interrupt   = 1'b0;
    tb_if.i_int_return  = 1'b0;
    tb_if.i_dec_ready   = 1'b1;

    // Reset values.
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // One-argument instruction, consumer always ready.
    sb_q.push_back('{14'h0005, 32'h0000_1234, 2'd1});
    fetch(16'h4005);
    fetch(16'h1234);
    check("one_arg_valid", 64'(tb_if.o_dec_valid),  64'(1));
    check("one_arg_opc",   64'(tb_if.o_dec_opcode), 64'(14'h0005));
    idle(1);
    check("one_arg_back_opc", 64'(tb_if.o_dec_valid), 64'(0));

    // Two arguments with back-pressure: output held, fetch stalled.
    tb_if.i_dec_ready = 1'b0;
    sb_q.push_back('{14'h0003, 32'hBBBB_AAAA, 2'd2});
    fetch(16'h8003);
    fetch(16'hAAAA);
    fetch(16'hBBBB);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 64'(tb_if.o_dec_valid),   64'(1));
      check("hold_ready", 64'(tb_if.o_fetch_ready), 64'(0));
      check("hold_args",  64'(tb_if.o_dec_args),    64'(32'hBBBB_AAAA));
      idle(1);
    end
    tb_if.i_dec_ready = 1'b1;
    idle(1);
    check("hold_release", 64'(tb_if.o_dec_valid), 64'(0));

    // Illegal word, NOP, zero-argument instruction.
    ill0 = ill_cnt;
    fetch(16'hC001);
    idle(2);
    check("illegal_pulse_once", 64'(ill_cnt), 64'(ill0 + 1));
    check("illegal_no_issue",   64'(tb_if.o_dec_valid), 64'(0));
    fetch(16'h0000);
    idle(2);
    check("nop_no_issue", 64'(tb_if.o_dec_valid), 64'(0));
    sb_q.push_back('{14'h0007, 32'h0000_0000, 2'd0});
    fetch(16'h0007);
    check("zero_arg_valid", 64'(tb_if.o_dec_valid), 64'(1));
    check("zero_arg_nargs", 64'(tb_if.o_dec_nargs), 64'(0));
    idle(1);

    // Interrupt mid-instruction, run another, then resume.
    fetch(16'h8009);
    fetch(16'h1111);
    pulse_int();
    check("int_to_opc_args_cleared", 64'(tb_if.o_dec_args), 64'(0));
    sb_q.push_back('{14'h0002, 32'h0000_2222, 2'd1});
    fetch(16'h4002);
    fetch(16'h2222);
    idle(1);
    pulse_ret();
    sb_q.push_back('{14'h0009, 32'h3333_1111, 2'd2});
    fetch(16'h3333);
    check("resume_valid", 64'(tb_if.o_dec_valid), 64'(1));
    idle(1);

    // Second interrupt overwrites the shadow; return restores the newer context.
    ovf0 = ovf_cnt;
    fetch(16'h8009);
    fetch(16'h1111);
    pulse_int();
    idle(1);
    check("first_int_no_overflow", 64'(ovf_cnt), 64'(ovf0));
    fetch(16'h800A);
    fetch(16'h4444);
    pulse_int();
    idle(1);
    check("overflow_pulse_once", 64'(ovf_cnt), 64'(ovf0 + 1));
    pulse_ret();
    sb_q.push_back('{14'h000A, 32'h5555_4444, 2'd2});
    fetch(16'h5555);
    idle(1);

    // Interrupt during ISSUE has no effect.
    tb_if.i_dec_ready = 1'b0;
    sb_q.push_back('{14'h0007, 32'h0000_0000, 2'd0});
    fetch(16'h0007);
    pulse_int();
    check("int_in_issue_valid", 64'(tb_if.o_dec_valid), 64'(1));
    check("int_in_issue_opc",   64'(tb_if.o_dec_opcode), 64'(14'h0007));
    tb_if.i_dec_ready = 1'b1;
    idle(2);
    check("int_in_issue_no_ovf", 64'(ovf_cnt), 64'(ovf0 + 1));

    // Reset mid-instruction with a saved shadow: everything discarded.
    ill0 = ill_cnt;
    ovf0 = ovf_cnt;
    fetch(16'h8001);
    fetch(16'h6666);
    pulse_int();
    fetch(16'h4001);
    rst = 1'b1;
    #2;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    pulse_ret();
    check("post_rst_ret_ignored", 64'(tb_if.o_fetch_ready), 64'(1));
    sb_q.push_back('{14'h0007, 32'h0000_0000, 2'd0});
    fetch(16'h0007);
    check("post_rst_shadow_clear", 64'(tb_if.o_dec_valid), 64'(1));
    idle(2);
    check("post_rst_no_pulses", 64'(ill_cnt + ovf_cnt), 64'(ill0 + ovf0));

    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
